// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared definitions for the WS2812 pixel feeder.
//   - GRB word width and channel field offsets
//   - feeder FSM state encoding
//   - frame timer period computation and per-channel brightness scaling
package ws2812_pkg;

  localparam int unsigned WS2812_WIDTH = 24;
  localparam int unsigned CH_W         = 8;
  localparam int unsigned G_OFS        = 16;
  localparam int unsigned R_OFS        = 8;
  localparam int unsigned B_OFS        = 0;

  typedef struct packed {
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] b;
  } grb_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_LOAD    = 2'd2,
    ST_PRESENT = 2'd3
  } state_t;

  // Cycles between automatic refreshes; 0 means the timer is disabled.
  function automatic int unsigned frame_period(input int unsigned clk_fre,
                                               input int unsigned frame_hz);
    return (frame_hz == 0) ? 0 : clk_fre / frame_hz;
  endfunction

  // (c * (b+1)) >> 8: b=255 is identity, b=0 blanks the channel.
  function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] c,
                                               input logic [CH_W-1:0] b);
    logic [16:0] p;
    p = 17'(c) * (17'(b) + 17'd1);
    return CH_W'(p >> 8);
  endfunction

  function automatic grb_t scale_px(input logic [WS2812_WIDTH-1:0] px,
                                    input logic [CH_W-1:0] b);
    grb_t o;
    o.g = scale_ch(px[G_OFS +: CH_W], b);
    o.r = scale_ch(px[R_OFS +: CH_W], b);
    o.b = scale_ch(px[B_OFS +: CH_W], b);
    return o;
  endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// ws2812_pixel_ram: simple dual-port pixel store, read-first, 1-cycle registered read.
//   clk           : clock
//   we/waddr/wdata: write port (caller filters out-of-range addresses)
//   raddr/rdata   : read port, rdata valid the cycle after raddr is presented
// Contents are not touched by reset and power up as zero.
module ws2812_pixel_ram
  import ws2812_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [WS2812_WIDTH-1:0] wdata,
  input  logic [AW-1:0]           raddr,
  output logic [WS2812_WIDTH-1:0] rdata
);

  logic [WS2812_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  // Read samples the array before this edge's write lands (read-first).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ws2812_pixel_feeder.sv
// ws2812_pixel_feeder: streams a brightness-scaled frame of GRB pixels to a
// WS2812 serializer over a valid/ready handshake.
//   clk, rst (sync, active-high)
//   wr_en/wr_addr/wr_data : pixel store write port
//   brightness            : global scale, latched at frame start
//   frame_start           : manual trigger pulse (ORed with the frame timer)
//   pix_valid/pix_data/pix_last/pix_ready : pixel stream to the serializer
//   busy, frame_done, frame_overrun       : frame status
module ws2812_pixel_feeder
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned CLK_FRE  = 27_000_000,
  parameter int unsigned FRAME_HZ = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [7:0]              wr_addr,
  input  logic [WS2812_WIDTH-1:0] wr_data,
  input  logic [7:0]              brightness,
  input  logic                    frame_start,
  output logic                    pix_valid,
  output logic [WS2812_WIDTH-1:0] pix_data,
  output logic                    pix_last,
  input  logic                    pix_ready,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    frame_overrun
);

  localparam int unsigned FRAME_PERIOD = frame_period(CLK_FRE, FRAME_HZ);
  localparam int unsigned RAM_AW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [7:0]  LAST_IDX     = 8'(NUM_LEDS - 1);

  // Free-running frame timer; independent of busy so the refresh rate stays fixed.
  logic timer_trig_c;
  generate
    if (FRAME_PERIOD == 0) begin : g_no_timer
      assign timer_trig_c = 1'b0;
    end else begin : g_timer
      localparam int unsigned TW    = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
      localparam logic [TW-1:0] T_MAX = TW'(FRAME_PERIOD - 1);
      logic [TW-1:0] tcnt_q;
      always_ff @(posedge clk) begin
        if (rst || tcnt_q == T_MAX) tcnt_q <= '0;
        else                        tcnt_q <= tcnt_q + TW'(1);
      end
      assign timer_trig_c = (tcnt_q == T_MAX);
    end
  endgenerate

  logic trig_c;
  assign trig_c = frame_start | timer_trig_c;

  // Pixel store
  logic                    ram_we_c;
  logic [WS2812_WIDTH-1:0] rd_data;
  logic [7:0]              rd_addr_q;

  assign ram_we_c = wr_en && (9'(wr_addr) < 9'(NUM_LEDS));

  ws2812_pixel_ram #(
    .DEPTH (NUM_LEDS),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .waddr (wr_addr[RAM_AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_addr_q[RAM_AW-1:0]),
    .rdata (rd_data)
  );

  // FSM state and registered outputs
  state_t                  state_q, state_d;
  logic [7:0]              rd_addr_d;
  logic [7:0]              bright_q, bright_d;
  logic                    valid_d, last_d, busy_d, done_d, overrun_d;
  logic [WS2812_WIDTH-1:0] data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rd_addr_q     <= '0;
      bright_q      <= '0;
      pix_valid     <= 1'b0;
      pix_data      <= '0;
      pix_last      <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_addr_q     <= rd_addr_d;
      bright_q      <= bright_d;
      pix_valid     <= valid_d;
      pix_data      <= data_d;
      pix_last      <= last_d;
      busy          <= busy_d;
      frame_done    <= done_d;
      frame_overrun <= overrun_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    bright_d  = bright_q;
    valid_d   = pix_valid;
    data_d    = pix_data;
    last_d    = pix_last;
    busy_d    = busy;
    done_d    = 1'b0;
    overrun_d = frame_overrun | (trig_c & busy);

    case (state_q)
      ST_IDLE: begin
        if (trig_c) begin
          state_d   = ST_FETCH;
          rd_addr_d = '0;
          bright_d  = brightness;
          busy_d    = 1'b1;
        end
      end
      // RAM is reading rd_addr_q this cycle.
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        data_d  = scale_px(rd_data, bright_q);
        last_d  = (rd_addr_q == LAST_IDX);
        valid_d = 1'b1;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (pix_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (pix_last) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            rd_addr_d = rd_addr_q + 8'd1;
            state_d   = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ws2812_pixel_feeder.sv
// Scoreboard bench for ws2812_pixel_feeder (NUM_LEDS=3, frame timer disabled).
module tb_ws2812_pixel_feeder;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [23:0] wr_data;
  logic [7:0]  brightness;
  logic        frame_start;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_last;
  logic        pix_ready;
  logic        busy;
  logic        frame_done;
  logic        frame_overrun;

  always #5 clk = ~clk;

  ws2812_pixel_feeder #(
    .NUM_LEDS (N),
    .CLK_FRE  (1000),
    .FRAME_HZ (0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .brightness    (brightness),
    .frame_start   (frame_start),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .pix_last      (pix_last),
    .pix_ready     (pix_ready),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_overrun (frame_overrun)
  );

  typedef struct packed {
    logic [23:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] model [N];
  int          checks = 0;
  int          failures = 0;
  int          done_seen = 0;
  int          exp_done = 0;
  bit          pending = 1'b0;
  bit          prev_last_acc = 1'b0;
  logic [23:0] held = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] scale_ref(input logic [23:0] c, input int b);
    int g, r, bl;
    g  = (int'(c[23:16]) * (b + 1)) / 256;
    r  = (int'(c[15:8])  * (b + 1)) / 256;
    bl = (int'(c[7:0])   * (b + 1)) / 256;
    return {8'(g), 8'(r), 8'(bl)};
  endfunction

  task automatic push(input logic [23:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic push_model(input int b);
    for (int i = 0; i < N; i++) push(scale_ref(model[i], b), (i == N - 1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input logic [7:0] a, input logic [23:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    if (int'(a) < N) model[int'(a)] = d;
  endtask

  // Trigger sampled on the first edge; first word must be valid after the third.
  task automatic start_frame(input logic [7:0] b, input bit chk_lat);
    brightness  = b;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    exp_done++;
    if (chk_lat) begin
      check("busy_on_trigger", 32'(busy), 32'd1);
      check("lat_edge1_valid", 32'(pix_valid), 32'd0);
      tick();
      check("lat_edge2_valid", 32'(pix_valid), 32'd0);
      tick();
      check("lat_edge3_valid", 32'(pix_valid), 32'd1);
    end
  endtask

  task automatic wait_valid();
    bit seen;
    seen = pix_valid;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = pix_valid;
    end
    check("wait_valid", 32'(seen), 32'd1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      seen = frame_done;
    end
    check("frame_done_seen", 32'(seen), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_pix_last"}, 32'(pix_last), 32'd0);
    check({tag, "_pix_data"}, 32'(pix_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_frame_overrun"}, 32'(frame_overrun), 32'd0);
  endtask

  // Monitor: pops on every transfer, checks hold stability and frame_done timing.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pending       = 1'b0;
      prev_last_acc = 1'b0;
    end else begin
      if (frame_done) begin
        done_seen++;
        check("frame_done_after_last", 32'(prev_last_acc), 32'd1);
      end
      if (pending) check("hold_stable", {7'd0, pix_valid, pix_data}, {8'd1, held});
      prev_last_acc = 1'b0;
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got 0x%0h expected none", pix_data);
        end else begin
          e = exp_q.pop_front();
          check("pix_data", 32'(pix_data), 32'(e.data));
          check("pix_last", 32'(pix_last), 32'(e.last));
        end
        prev_last_acc = pix_last;
      end
      pending = pix_valid && !pix_ready;
      held    = pix_data;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    brightness  = '0;
    frame_start = 1'b0;
    pix_ready   = 1'b1;
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;

    // Basic frame, identity brightness
    write_px(8'd0, 24'hFF0000);
    write_px(8'd1, 24'h00FF00);
    write_px(8'd2, 24'h0000FF);
    push(24'hFF0000, 1'b0);
    push(24'h00FF00, 1'b0);
    push(24'h0000FF, 1'b1);
    start_frame(8'd255, 1'b1);
    wait_done();

    // Scaling at brightness 127 and 0
    write_px(8'd0, 24'h804020);
    push(24'h402010, 1'b0);
    push(24'h007F00, 1'b0);
    push(24'h00007F, 1'b1);
    start_frame(8'd127, 1'b0);
    wait_done();
    push(24'h000000, 1'b0);
    push(24'h000000, 1'b0);
    push(24'h000000, 1'b1);
    start_frame(8'd0, 1'b0);
    wait_done();

    // Backpressure: hold word 2 for 10 cycles
    pix_ready = 1'b0;
    push_model(255);
    start_frame(8'd255, 1'b0);
    wait_valid();
    pix_ready = 1'b1;
    tick();
    pix_ready = 1'b0;
    wait_valid();
    repeat (10) tick();
    check("bp_valid_held", 32'(pix_valid), 32'd1);
    pix_ready = 1'b1;
    wait_done();

    // Out-of-range writes, overrun, mid-frame brightness change
    write_px(8'd3, 24'hABCDEF);
    write_px(8'd4, 24'hABCDEF);
    push_model(255);
    start_frame(8'd255, 1'b0);
    tick();
    frame_start = 1'b1;
    brightness  = 8'h10;
    tick();
    frame_start = 1'b0;
    check("overrun_set", 32'(frame_overrun), 32'd1);
    wait_done();
    repeat (4) tick();
    check("no_extra_frame_busy", 32'(busy), 32'd0);
    check("overrun_sticky", 32'(frame_overrun), 32'd1);

    // Write pixel 0 after it was fetched: visible only next frame
    push_model(255);
    start_frame(8'd255, 1'b1);
    write_px(8'd0, 24'h123456);
    wait_done();
    push_model(255);
    start_frame(8'd255, 1'b0);
    wait_done();

    // Reset during word 2, then restart from pixel 0
    pix_ready = 1'b0;
    push_model(255);
    start_frame(8'd255, 1'b0);
    wait_valid();
    pix_ready = 1'b1;
    tick();
    pix_ready = 1'b0;
    wait_valid();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("rst_mid");
    exp_q.delete();
    exp_done--;
    pix_ready = 1'b1;
    repeat (3) tick();
    check("no_done_after_abort", 32'(done_seen), 32'(exp_done));
    push_model(255);
    start_frame(8'd255, 1'b1);
    wait_done();

    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("frame_count", 32'(done_seen), 32'(exp_done));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
